// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 16-requester round-robin scheduler.
// Optional build macro used by the top: MUX_SCHED_TIMEOUT_EN.
package mux_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] PTR_RST = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating priority encoder: first set req bit searching upward from ptr+1,
// wrapping modulo 16.
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W-1:0] pos;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // 4-bit addition wraps naturally past requester 15
      pos = ptr + SEL_W'(1) + SEL_W'(k);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 single-bit path; streams the granted
// bit under valid/ready. Optional forced release: `define MUX_SCHED_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no holder; arbitrate req from ptr+1 each cycle
//   GRANT | sel owns the path; beats counted until req[sel] drops
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in_bits,
  input  logic             out_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             beat;
  logic [CNT_W-1:0] cnt_inc;
  logic             hold_done;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req[sel_q];
  assign out_bit   = in_bits[sel_q];
  assign beat      = out_valid && out_ready;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MUX_SCHED_TIMEOUT_EN
  // Release on the edge that completes the MAX_HOLD-th beat, so no extra beat slips out.
  assign hold_done = beat && (cnt_inc >= HOLD_LIM);
`else
  logic unused_hold_lim;
  assign unused_hold_lim = ^HOLD_LIM;
  assign hold_done       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          ptr_d   = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (beat) cnt_d = cnt_inc;
        // sel and beat_cnt are left as-is on release for observability
        if (!req[sel_q] || hold_done) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign beat_cnt = cnt_q;

endmodule
